// File: rtl/seg_scan_arbiter.sv
// Eight-digit seven-segment scanner with frame-aligned arbitration between a
// high-priority debug readout and a low-priority MMIO display value.
module seg_scan_arbiter #(
   parameter int NDIG        = 8,
   parameter int PWM_BITS    = 3,
   parameter int HOLD_FRAMES = 4
) (
   input  logic                clk_7seg,
   input  logic                Rst,
   input  logic                dbg_req,
   input  logic [31:0]         dbg_val,
   input  logic                mmio_valid,
   input  logic [31:0]         mmio_val,
   input  logic [PWM_BITS-1:0] brightness,
   input  logic                lz_blank,
   output logic [NDIG-1:0]     an,
   output logic [6:0]          sev_out,
   output logic                sel_dbg,
   output logic                frame_tick
);

   localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

   typedef enum logic [1:0] {IDLE, SHOW_MMIO, SHOW_DBG} state_t;

   function automatic logic [6:0] f_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'b0000001;
         4'h1: seg = 7'b1001111;
         4'h2: seg = 7'b0010010;
         4'h3: seg = 7'b0000110;
         4'h4: seg = 7'b1001100;
         4'h5: seg = 7'b0100100;
         4'h6: seg = 7'b0100000;
         4'h7: seg = 7'b0001111;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0000100;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b1100000;
         4'hC: seg = 7'b0110001;
         4'hD: seg = 7'b1000010;
         4'hE: seg = 7'b0110000;
         default: seg = 7'b0111000;
      endcase
      return seg;
   endfunction

   logic [PWM_BITS-1:0] r_s;
   logic [DW-1:0]       r_d;
   state_t              r_state;
   logic [HW-1:0]       r_hold;
   logic [31:0]         r_shadow;
   logic                r_sel_dbg;
   logic                r_frame_tick;
   logic [NDIG-1:0]     r_an_p1;
   logic [6:0]          r_sev_p1;

   logic        w_frame_end;
   logic        w_permit;
   state_t      w_req;
   state_t      w_target;
   logic [31:0] w_target_val;
   logic [31:0] w_shift;
   logic        w_blank;
   logic        w_lit;

   assign w_frame_end = (r_d == DW'(NDIG - 1)) && (&r_s);

   // IDLE may switch at any frame boundary; shown sources only once the hold expires.
   assign w_permit = (r_state == IDLE) || (r_hold == HW'(HOLD_FRAMES - 1));

   always_comb begin
      w_req = IDLE;
      if (dbg_req)
         w_req = SHOW_DBG;
      else if (mmio_valid)
         w_req = SHOW_MMIO;
   end

   assign w_target     = w_permit ? w_req : r_state;
   assign w_target_val = (w_target == SHOW_DBG)  ? dbg_val  :
                         (w_target == SHOW_MMIO) ? mmio_val : 32'd0;

   // Control: scan counters and arbiter, all state advances on frame_end only.
   always_ff @(posedge clk_7seg) begin
      if (Rst) begin
         r_s          <= '0;
         r_d          <= '0;
         r_state      <= IDLE;
         r_hold       <= '0;
         r_shadow     <= '0;
         r_sel_dbg    <= 1'b0;
         r_frame_tick <= 1'b0;
      end else begin
         r_s          <= r_s + 1'b1;
         r_frame_tick <= w_frame_end;
         if (&r_s)
            r_d <= (r_d == DW'(NDIG - 1)) ? '0 : r_d + 1'b1;
         if (w_frame_end) begin
            r_shadow  <= w_target_val;
            r_sel_dbg <= (w_target == SHOW_DBG);
            if (w_target != r_state) begin
               r_state <= w_target;
               r_hold  <= '0;
            end else if (r_hold != HW'(HOLD_FRAMES - 1)) begin
               r_hold  <= r_hold + 1'b1;
            end
         end
      end
   end

   assign w_shift = r_shadow >> {r_d, 2'b00};
   assign w_blank = lz_blank && (r_d != '0) && (w_shift == 32'd0);
   assign w_lit   = (r_state != IDLE) && (r_s <= brightness) && !w_blank;

   // Stage p1: registered anode/segment drive, one cycle behind the counters.
   always_ff @(posedge clk_7seg) begin
      if (Rst) begin
         r_an_p1  <= '1;
         r_sev_p1 <= 7'h7F;
      end else if (w_lit) begin
         r_an_p1  <= ~(NDIG'(1) << r_d);
         r_sev_p1 <= f_decode(w_shift[3:0]);
      end else begin
         r_an_p1  <= '1;
         r_sev_p1 <= 7'h7F;
      end
   end

   assign an         = r_an_p1;
   assign sev_out    = r_sev_p1;
   assign sel_dbg    = r_sel_dbg;
   assign frame_tick = r_frame_tick;

endmodule

// File: doc/seg_scan_arbiter.md
Name: seg_scan_arbiter

Overview:
- Drives the 8-digit seven-segment display on the board.
- Shares the display between two requesters:
  - core debug/prog readout, high priority;
  - MMIO display register output, low priority.
- Source switches happen only at frame boundaries, with a minimum hold, so the display never tears or flickers.
- Also handles digit scanning, brightness PWM and optional leading-zero blanking. Replaces the free-running anode ring in the top level.

Parameters:
- NDIG, 8, number of digits scanned (anode width).
- PWM_BITS, 3, log2 of clk_7seg cycles per digit slot.
- HOLD_FRAMES, 4, minimum complete frames a newly selected source is displayed before another switch.

Ports:
- clk_7seg  in  1  scan clock.
- Rst  in  1  synchronous, active-high reset.
- dbg_req  in  1  debug source requests display (prog | debug).
- dbg_val  in  32  debug value.
- mmio_valid  in  1  MMIO source requests display.
- mmio_val  in  32  MMIO display value.
- brightness  in  PWM_BITS  on-time per slot is brightness+1 cycles.
- lz_blank  in  1  enable leading-zero blanking.
- an  out  NDIG  anodes, active low; digit i is bit i.
- sev_out  out  7  segments, active low.
- sel_dbg  out  1  1 while the debug source is displayed.
- frame_tick  out  1  one-cycle pulse at every frame_end.

Behaviour:
- Interface: reset Rst, synchronous, active-high; clock clk_7seg.
- Counters: slot counter s (PWM_BITS) and digit counter d (0..NDIG-1).
  - s increments every cycle; when s wraps, d increments; d wraps NDIG-1 -> 0.
  - Frame = NDIG * 2^PWM_BITS cycles (64 at defaults).
  - frame_end = cycle where d==NDIG-1 and s==all-ones.
- Arbiter states: IDLE, SHOW_MMIO, SHOW_DBG. State is evaluated only on frame_end:
  - From IDLE: dbg_req -> SHOW_DBG; else mmio_valid -> SHOW_MMIO; else stay IDLE.
  - From SHOW_x: a switch is permitted only if hold_cnt == HOLD_FRAMES-1.
    - When permitted: dbg_req -> SHOW_DBG; else mmio_valid -> SHOW_MMIO; else IDLE.
    - When not permitted: stay, and hold_cnt increments.
  - On entering a new state, hold_cnt <= 0. When staying, hold_cnt increments, saturating at HOLD_FRAMES-1.
  - dbg_req and mmio_valid both high: debug wins.
  - Requests are sampled only on frame_end; pulses between frame_ends are ignored.
- Shadow register:
  - On frame_end, shadow <= value of the newly selected source; 0 if the next state is IDLE.
  - The shadow is constant for the whole frame.
  - frame_tick=1 on the cycle after frame_end.
  - sel_dbg is registered and reflects the state.
- Digit output, per cycle, computed from (d, s, state, shadow) and registered, so there is 1 cycle of latency.
  - Digit is lit iff state != IDLE, and s <= brightness, and the digit is not blanked.
  - When lit: an = ~(1<<d) and sev_out = decode(shadow[4d+3:4d]).
  - When not lit: an = all ones and sev_out = 7'h7F.
- Leading-zero blanking (lz_blank=1): digit d is blanked if every nibble at index >= d is zero, except digit 0, which is never blanked.
- Decode table, nibble 0..F: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
- Reset values: an=all ones, sev_out=7'h7F, sel_dbg=0, frame_tick=0, state=IDLE, d=s=0, hold_cnt=0, shadow=0.
- Rst asserted mid-frame: all the above take effect on the next edge and scanning restarts at digit 0. No partial-frame carry-over.

Test Plan:
- Reset, then mmio_valid=1, mmio_val=0x12345678, brightness=7:
  - First 64 cycles: an=FF.
  - frame_tick pulses once.
  - Next frame: digit 0 slot an=FE, sev_out=0000000 ("8") for 8 cycles; digit 7 slot an=7F, sev_out=1001111.
- brightness=0, same value: each digit slot shows an low for exactly 1 of 8 cycles, all ones for the other 7.
- HOLD_FRAMES=4, SHOW_MMIO just entered, dbg_req=1 from mid-frame 1:
  - Display stays on MMIO for 4 complete frames, then sel_dbg=1 and dbg_val is displayed.
  - dbg_req drops later: debug is still held for 4 frames, then the display returns to MMIO.
- lz_blank=1, shadow value 0x00000A05: digits 3..7 have an=FF during their slots; digits 0..2 show 5, 0, A (0100100, 0000001, 0001000).
- lz_blank=1, value 0: only digit 0 is lit, with sev_out=0000001. mmio_valid and dbg_req both low at a permitted frame_end: state -> IDLE and the display is fully blank.
- Rst pulsed at cycle 37 of a frame: the next cycle shows an=FF, sev_out=7F, sel_dbg=0, and the scan restarts at d=0, s=0.
